// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Brief    : RV32I opcode/funct constants and ALU operation encoding.
// Revision : 1.0
// ============================================================================
package rv32i_pkg;

  localparam logic [6:0] OP         = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/rv_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rv_scoreboard
// Brief    : 32-entry register busy table, one set port, one clear port, two
//            read ports. Set wins over a same-index clear; x0 is never busy.
// Revision : 1.0
// ============================================================================
module rv_scoreboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rd_idx_a,
  output logic       rd_busy_a,
  input  logic [4:0] rd_idx_b,
  output logic       rd_busy_b
);

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en) w_set_mask[set_idx] = 1'b1;
    if (clr_en) w_clr_mask[clr_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end
  end

  assign rd_busy_a = r_busy[rd_idx_a];
  assign rd_busy_b = r_busy[rd_idx_b];

endmodule
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode
// Brief    : RV32I ADD/SUB decode stage with RAW scoreboard and valid/ready
//            handshakes. Define DECODE_OPIMM_EN to also decode ADDI.
// Revision : 1.0
// ============================================================================
module instr_decode
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            dec_valid,
  input  logic            dec_ready,
  output alu_op_t         dec_op,
  output logic [XLEN-1:0] dec_opa,
  output logic [XLEN-1:0] dec_opb,
  output logic [4:0]      dec_rd,
  output logic            dec_we,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic            w_is_rtype;
  logic            w_is_addi;
  logic            w_legal;
  logic            w_rs1_busy;
  logic            w_rs2_busy;
  logic            w_hazard;
  logic            w_accept;
  logic            w_set_en;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_opb;

  logic            r_dec_valid;
  alu_op_t         r_dec_op;
  logic [XLEN-1:0] r_dec_opa;
  logic [XLEN-1:0] r_dec_opb;
  logic [4:0]      r_dec_rd;
  logic            r_dec_we;
  logic            r_illegal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_rd     = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign w_is_rtype = (w_opcode == OP) && (w_funct3 == F3_ADD_SUB) &&
                      ((w_funct7 == F7_ADD) || (w_funct7 == F7_SUB));
`ifdef DECODE_OPIMM_EN
  assign w_is_addi  = (w_opcode == OP_IMM) && (w_funct3 == F3_ADD_SUB);
`else
  assign w_is_addi  = 1'b0;
`endif
  assign w_legal    = w_is_rtype || w_is_addi;

  // rs2 is only a real source for the OP major opcode
  assign w_hazard    = w_rs1_busy || ((w_opcode == OP) && w_rs2_busy);
  assign instr_ready = (!r_dec_valid || dec_ready) && !w_hazard;
  assign w_accept    = instr_valid && instr_ready;
  assign w_set_en    = w_accept && w_legal && (w_rd != 5'd0);

  assign w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_opb = w_is_addi ? w_imm : rs2_data;

  rv_scoreboard u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .set_en    (w_set_en),
    .set_idx   (w_rd),
    .clr_en    (wb_valid),
    .clr_idx   (wb_rd),
    .rd_idx_a  (rs1_addr),
    .rd_busy_a (w_rs1_busy),
    .rd_idx_b  (rs2_addr),
    .rd_busy_b (w_rs2_busy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dec_valid <= 1'b0;
      r_dec_op    <= ALU_ADD;
      r_dec_opa   <= '0;
      r_dec_opb   <= '0;
      r_dec_rd    <= '0;
      r_dec_we    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_dec_valid <= 1'b1;
        r_dec_op    <= (w_is_rtype && instr[30]) ? ALU_SUB : ALU_ADD;
        r_dec_opa   <= rs1_data;
        r_dec_opb   <= w_opb;
        r_dec_rd    <= w_rd;
        r_dec_we    <= (w_rd != 5'd0);
      end else if (w_accept || dec_ready) begin
        // consumed, or replaced by an illegal word that never issues
        r_dec_valid <= 1'b0;
      end
    end
  end

  assign dec_valid = r_dec_valid;
  assign dec_op    = r_dec_op;
  assign dec_opa   = r_dec_opa;
  assign dec_opb   = r_dec_opb;
  assign dec_rd    = r_dec_rd;
  assign dec_we    = r_dec_we;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode
// Brief    : Self-checking bench for instr_decode (directed + random vs model).
// Revision : 1.0
// ============================================================================
module tb_instr_decode;
  import rv32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  alu_op_t     dec_op;
  logic [31:0] dec_opa;
  logic [31:0] dec_opb;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  instr_decode #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_op      (dec_op),
    .dec_opa     (dec_opa),
    .dec_opb     (dec_opb),
    .dec_rd      (dec_rd),
    .dec_we      (dec_we),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd,
                                        input logic [2:0] f3);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] d = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0, 1:    return rtype(7'b0000000, b, a, d, 3'b000);
      2:       return rtype(7'b0100000, b, a, d, 3'b000);
      3:       return rtype(7'b0000001, b, a, d, 3'($urandom_range(0, 1)));
      4:       return {12'($urandom), a, 3'($urandom_range(0, 1)), d, 7'b0010011};
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    wb_valid    = 1'b0;
    dec_ready   = 1'b1;
    reset       = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [71:0] exp_t;
    tick();
    tick();
    exp_t = {1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0};
    checks++;
    if ({dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== exp_t) begin
      errors++;
      $display("FAIL reset_dec: got %h want %h", {dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we}, exp_t);
    end
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add_sub(input logic sub);
    logic [71:0] exp_t;
    do_reset();
    rs1_data    = 32'd5;
    rs2_data    = 32'd11;
    instr       = rtype(sub ? 7'b0100000 : 7'b0000000, 5'd2, 5'd1, 5'd3, 3'b000);
    instr_valid = 1'b1;
    #1;
    checks++;
    if ({instr_ready, rs1_addr, rs2_addr} !== {1'b1, 5'd1, 5'd2}) begin
      errors++;
      $display("FAIL addsub_ready_addr: got %b/%0d/%0d want 1/1/2", instr_ready, rs1_addr, rs2_addr);
    end
    tick();
    instr_valid = 1'b0;
    exp_t = {1'b1, sub ? ALU_SUB : ALU_ADD, 32'd5, 32'd11, 5'd3, 1'b1};
    checks++;
    if ({dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== exp_t) begin
      errors++;
      $display("FAIL addsub_dec(sub=%0d): got %h want %h", sub, {dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we}, exp_t);
    end
  endtask

  task automatic test_hazard();
    logic [71:0] exp_t;
    do_reset();
    rs1_data    = 32'd5;
    rs2_data    = 32'd11;
    instr       = rtype(7'b0000000, 5'd2, 5'd1, 5'd3, 3'b000);
    instr_valid = 1'b1;
    tick();
    instr = rtype(7'b0100000, 5'd1, 5'd3, 5'd4, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall[%0d]: got %b want 0", i, instr_ready); end
      tick();
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL hazard_wb_cycle: got %b want 0", instr_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b want 1", instr_ready); end
    tick();
    instr_valid = 1'b0;
    exp_t = {1'b1, ALU_SUB, 32'd5, 32'd11, 5'd4, 1'b1};
    checks++;
    if ({dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== exp_t) begin
      errors++;
      $display("FAIL hazard_dec: got %h want %h", {dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we}, exp_t);
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0] exp_t;
    do_reset();
    rs1_data    = 32'd5;
    rs2_data    = 32'd11;
    instr       = rtype(7'b0000000, 5'd2, 5'd1, 5'd3, 3'b000);
    instr_valid = 1'b1;
    tick();
    dec_ready = 1'b0;
    instr     = rtype(7'b0000000, 5'd7, 5'd6, 5'd5, 3'b000);
    rs1_data  = 32'd99;
    rs2_data  = 32'd77;
    exp_t = {1'b1, ALU_ADD, 32'd5, 32'd11, 5'd3, 1'b1};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({instr_ready, dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== {1'b0, exp_t}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h want %h", i, {instr_ready, dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we}, {1'b0, exp_t});
      end
      tick();
    end
    dec_ready = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got %b want 1", instr_ready); end
    tick();
    instr_valid = 1'b0;
    exp_t = {1'b1, ALU_ADD, 32'd99, 32'd77, 5'd5, 1'b1};
    checks++;
    if ({dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== exp_t) begin
      errors++;
      $display("FAIL bp_next_dec: got %h want %h", {dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we}, exp_t);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    instr       = 32'h0000_007F;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({illegal, dec_valid} !== 2'b10) begin errors++; $display("FAIL ill_pulse: got ill=%b dv=%b want 1/0", illegal, dec_valid); end
    tick();
    checks++;
    if ({illegal, dec_valid} !== 2'b00) begin errors++; $display("FAIL ill_onecycle: got ill=%b dv=%b want 0/0", illegal, dec_valid); end
    // bad funct3 targeting x3 must leave x3 free
    instr       = rtype(7'b0000000, 5'd2, 5'd1, 5'd3, 3'b001);
    instr_valid = 1'b1;
    tick();
    instr = rtype(7'b0000000, 5'd3, 5'd3, 5'd6, 3'b000);
    #1;
    checks++;
    if ({illegal, dec_valid, instr_ready} !== 3'b101) begin
      errors++;
      $display("FAIL ill_noscore: got ill=%b dv=%b rdy=%b want 1/0/1", illegal, dec_valid, instr_ready);
    end
    tick();
    rs1_data = 32'd5;
    instr    = {12'hFFB, 5'd1, 3'b000, 5'd3, 7'b0010011};
    tick();
    instr_valid = 1'b0;
`ifdef DECODE_OPIMM_EN
    checks++;
    if ({illegal, dec_valid, dec_op, dec_opa, dec_opb, dec_rd} !== {1'b0, 1'b1, ALU_ADD, 32'd5, 32'hFFFF_FFFB, 5'd3}) begin
      errors++;
      $display("FAIL addi_dec: got ill=%b dv=%b opa=%h opb=%h rd=%0d", illegal, dec_valid, dec_opa, dec_opb, dec_rd);
    end
`else
    checks++;
    if ({illegal, dec_valid} !== 2'b10) begin errors++; $display("FAIL opimm_illegal: got ill=%b dv=%b want 1/0", illegal, dec_valid); end
`endif
  endtask

  task automatic test_reset_midstall();
    logic [71:0] exp_t;
    do_reset();
    rs1_data    = 32'd5;
    rs2_data    = 32'd11;
    instr       = rtype(7'b0000000, 5'd2, 5'd1, 5'd3, 3'b000);
    instr_valid = 1'b1;
    tick();
    instr     = rtype(7'b0100000, 5'd1, 5'd3, 5'd4, 3'b000);
    dec_ready = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_pre: got %b want 0", instr_ready); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({dec_valid, illegal, dec_we, dec_rd, instr_ready} !== {3'b000, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_async: got dv=%b ill=%b we=%b rd=%0d rdy=%b want 0/0/0/0/1", dec_valid, illegal, dec_we, dec_rd, instr_ready);
    end
    @(negedge clock);
    reset     = 1'b1;
    dec_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    exp_t = {1'b1, ALU_SUB, 32'd5, 32'd11, 5'd4, 1'b1};
    checks++;
    if ({dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== exp_t) begin
      errors++;
      $display("FAIL rst_resume_dec: got %h want %h", {dec_valid, dec_op, dec_opa, dec_opb, dec_rd, dec_we}, exp_t);
    end
  endtask

  task automatic test_random();
    bit          m_busy[32];
    logic        m_valid, m_ill, m_we, legal, exp_ready, acc;
    alu_op_t     m_op;
    logic [31:0] m_opa, m_opb;
    logic [4:0]  m_rd, rs1, rs2, rd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    do_reset();
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    m_valid = 1'b0; m_ill = 1'b0; m_we = 1'b0; m_op = ALU_ADD;
    m_opa = '0; m_opb = '0; m_rd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      instr_valid = ($urandom_range(0, 9) < 7);
      instr       = gen_instr();
      rs1_data    = $urandom;
      rs2_data    = $urandom;
      dec_ready   = ($urandom_range(0, 3) != 0);
      wb_valid    = ($urandom_range(0, 9) < 3);
      wb_rd       = 5'($urandom_range(0, 7));
      opc = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
      rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
      legal = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000 || f7 == 7'b0100000);
`ifdef DECODE_OPIMM_EN
      legal = legal || ((opc == 7'b0010011) && (f3 == 3'b000));
`endif
      exp_ready = (!m_valid || dec_ready) && !(m_busy[rs1] || (opc == 7'b0110011 && m_busy[rs2]));
      #1;
      checks++;
      if ({instr_ready, rs1_addr, rs2_addr} !== {exp_ready, rs1, rs2}) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %b/%0d/%0d want %b/%0d/%0d", cyc, instr_ready, rs1_addr, rs2_addr, exp_ready, rs1, rs2);
      end
      @(posedge clock);
      acc   = instr_valid && exp_ready;
      m_ill = acc && !legal;
      if (acc && legal) begin
        m_valid = 1'b1;
        m_op    = (opc == 7'b0110011 && instr[30]) ? ALU_SUB : ALU_ADD;
        m_opa   = rs1_data;
        m_opb   = (opc == 7'b0110011) ? rs2_data : {{20{instr[31]}}, instr[31:20]};
        m_rd    = rd;
        m_we    = (rd != 5'd0);
      end else if (acc || dec_ready) begin
        m_valid = 1'b0;
      end
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (acc && legal && rd != 5'd0) m_busy[rd] = 1'b1;
      #1;
      checks++;
      if ({dec_valid, illegal} !== {m_valid, m_ill}) begin
        errors++;
        $display("FAIL rnd_flags[%0d]: got dv=%b ill=%b want %b/%b", cyc, dec_valid, illegal, m_valid, m_ill);
      end
      if (m_valid) begin
        checks++;
        if ({dec_op, dec_opa, dec_opb, dec_rd, dec_we} !== {m_op, m_opa, m_opb, m_rd, m_we}) begin
          errors++;
          $display("FAIL rnd_dec[%0d]: got %h want %h", cyc, {dec_op, dec_opa, dec_opb, dec_rd, dec_we}, {m_op, m_opa, m_opb, m_rd, m_we});
        end
      end
    end
    instr_valid = 1'b0;
    wb_valid    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub(1'b0);
    test_add_sub(1'b1);
    test_hazard();
    test_back_to_back();
    test_illegal();
    test_reset_midstall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width of register operands.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port: instr_valid  input  1  upstream instruction word present.
REQ-005 SHALL have port: instr_ready  output  1  decoder accepts instr this cycle.
REQ-006 SHALL have port: instr  input  32  RV32I instruction word (rs1 [19:15], rs2 [24:20], rd [11:7], opcode [6:0]).
REQ-007 SHALL have ports: rs1_addr, rs2_addr  output  5  register-file read addresses; rs1_data, rs2_data  input  XLEN  combinational read data.
REQ-008 SHALL have ports: wb_valid  input  1, wb_rd  input  5  writeback retire notification.
REQ-009 SHALL have ports: dec_valid  output  1, dec_ready  input  1, dec_op  output  alu_op_t, dec_opa/dec_opb  output  XLEN, dec_rd  output  5, dec_we  output  1.
REQ-010 SHALL have port: illegal  output  1  one-cycle pulse on acceptance of an unsupported instruction.

Function
REQ-011 SHALL drive rs1_addr = instr[19:15], rs2_addr = instr[24:20] combinationally at all times.
REQ-012 SHALL decode opcode 0110011 with funct3 000, funct7 0000000 as ADD; funct7 0100000 as SUB (instr[30] selects).
REQ-013 SHALL treat any other opcode/funct3/funct7 combination as illegal.
REQ-014 SHALL accept when instr_valid && instr_ready; instr_ready = (!dec_valid || dec_ready) && !hazard.
REQ-015 SHALL register dec_* outputs one cycle after acceptance (latency 1), dec_opa = rs1_data, dec_opb = rs2_data sampled at acceptance.
REQ-016 SHALL hold all dec_* outputs stable while dec_valid && !dec_ready.
REQ-017 SHALL clear dec_valid after a dec_valid && dec_ready cycle with no new acceptance.
REQ-018 SHALL keep a 32-bit busy scoreboard; hazard = busy[rs1] or busy[rs2] (rs2 only for R-type).
REQ-019 SHALL set busy[rd] on acceptance of a legal instruction with rd != 0; dec_we = (rd != 0).
REQ-020 SHALL clear busy[wb_rd] on wb_valid; simultaneous set and clear of same index SHALL leave it set.
REQ-021 SHALL evaluate hazard on registered busy state; a clear lands the cycle after wb_valid.
REQ-022 SHALL never mark x0 busy and never stall on x0.
REQ-023 SHALL on illegal acceptance: pulse illegal for one cycle, not assert dec_valid, not touch the scoreboard.

Reset
REQ-024 SHALL on reset assertion immediately clear dec_valid, illegal, dec_we, all busy bits; dec_op = ALU_ADD, dec_opa/opb/rd = 0.
REQ-025 SHALL discard any stalled or in-flight instruction on reset mid-operation; instr_ready follows REQ-014 from reset values.

Configuration
REQ-026 SHALL with DECODE_OPIMM_EN defined also decode opcode 0010011 funct3 000 (ADDI): dec_op = ALU_ADD, dec_opb = sign-extended instr[31:20], no rs2 hazard check.
REQ-027 SHALL without DECODE_OPIMM_EN treat opcode 0010011 as illegal.

Structure
REQ-028 SHALL take opcode constants (OP, OP_IMM), funct constants and alu_op_t enum (ALU_ADD, ALU_SUB) from shared package rv32i_pkg.
REQ-029 SHALL implement the busy table as sub-module rv_scoreboard (set port, clear port, two read ports).

Verification
REQ-030 SHALL cover: rs1_data=5, rs2_data=11, add x3,x1,x2 -> next cycle dec_valid=1, ALU_ADD, opa=5, opb=11, rd=3, we=1.
REQ-031 SHALL cover: same operands, instr[30]=1 -> ALU_SUB, rd=3, we=1.
REQ-032 SHALL cover: add x3,x1,x2 then sub x4,x3,x1 -> instr_ready=0 until wb_valid with wb_rd=3, accepted the cycle after.
REQ-033 SHALL cover: dec_ready=0 for 4 cycles -> dec_* stable, instr_ready=0; next instruction accepted when dec_ready returns to 1.
REQ-034 SHALL cover: instr=0x0000007F -> illegal pulse 1 cycle, dec_valid stays 0, no busy bit set.
REQ-035 SHALL cover: reset asserted while stalled on x3 -> dec_valid=0, busy cleared, stalled instruction accepted after reset release.
